// File: rtl/bolme_denetleyici_pkg.sv
// Shared types and constants for the iterative RV32M divide controller.
package bolme_denetleyici_pkg;

  localparam int unsigned VERI_BIT_VARSAYILAN = 32;
  localparam int unsigned SAYAC_W             = 6;

  // Micro-op unit field value that routes a uop to the divide unit.
  localparam int unsigned UOP_BIRIM_W     = 3;
  localparam logic [UOP_BIRIM_W-1:0] UOP_BIRIM_BOLME = 3'd4;

  typedef enum logic [1:0] {
    BOL_DIV  = 2'b00,
    BOL_DIVU = 2'b01,
    BOL_REM  = 2'b10,
    BOL_REMU = 2'b11
  } bol_kod_t;

  typedef enum logic [2:0] {
    BOSTA   = 3'd0,
    HESAPLA = 3'd1,
    DUZELT  = 3'd2,
    OZEL    = 3'd3,
    BITTI   = 3'd4
  } durum_t;

  // REM/REMU return the remainder, DIV/DIVU the quotient.
  function automatic logic kalan_mi(input bol_kod_t kod);
    return (kod == BOL_REM) || (kod == BOL_REMU);
  endfunction

  // DIV/REM treat operands as two's complement.
  function automatic logic isaretli_mi(input bol_kod_t kod);
    return (kod == BOL_DIV) || (kod == BOL_REM);
  endfunction

endpackage

// File: rtl/bolme_denetleyici_if.sv
// Request/response bundle between the execute stage (yurut) and the divider.
interface bolme_denetleyici_if #(
  parameter int unsigned VERI_BIT = 32
);
  logic                bosalt_i;
  logic                istek_gecerli_i;
  logic [1:0]          istek_kod_i;
  logic [VERI_BIT-1:0] bolunen_i;
  logic [VERI_BIT-1:0] bolen_i;
  logic                istek_hazir_o;
  logic                sonuc_gecerli_o;
  logic [VERI_BIT-1:0] sonuc_o;
  logic                duraklat_o;

  modport master (
    output bosalt_i, istek_gecerli_i, istek_kod_i, bolunen_i, bolen_i,
    input  istek_hazir_o, sonuc_gecerli_o, sonuc_o, duraklat_o
  );

  modport slave (
    input  bosalt_i, istek_gecerli_i, istek_kod_i, bolunen_i, bolen_i,
    output istek_hazir_o, sonuc_gecerli_o, sonuc_o, duraklat_o
  );
endinterface

// File: rtl/bolme_denetleyici_bolme_adimi.sv
// One restoring-division step on the {remainder, quotient} pair.
module bolme_adimi #(
  parameter int unsigned VERI_BIT = 32
) (
  input  logic [VERI_BIT-1:0] kalan,
  input  logic [VERI_BIT-1:0] bolum,
  input  logic [VERI_BIT-1:0] bolen,
  output logic [VERI_BIT-1:0] sonraki_kalan,
  output logic [VERI_BIT-1:0] sonraki_bolum
);

  logic [VERI_BIT:0] kaydirilmis;
  logic [VERI_BIT:0] deneme;
  logic              odunc;

  // Shift in the next dividend bit, trial-subtract, keep the result if no borrow.
  always_comb begin
    kaydirilmis   = {kalan, bolum[VERI_BIT-1]};
    deneme        = kaydirilmis - {1'b0, bolen};
    odunc         = deneme[VERI_BIT];
    sonraki_kalan = odunc ? kaydirilmis[VERI_BIT-1:0] : deneme[VERI_BIT-1:0];
    sonraki_bolum = {bolum[VERI_BIT-2:0], ~odunc};
  end

endmodule

// File: rtl/bolme_denetleyici.sv
// Iterative DIV/DIVU/REM/REMU controller: handshake, FSM, sign handling.
module bolme_denetleyici
  import bolme_denetleyici_pkg::*;
#(
  parameter int unsigned VERI_BIT = VERI_BIT_VARSAYILAN
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  bolme_denetleyici_if.slave    bif
);

  localparam logic [VERI_BIT-1:0] EN_KUCUK = {1'b1, {(VERI_BIT-1){1'b0}}};
  localparam logic [SAYAC_W-1:0]  SON_SAYI = SAYAC_W'(VERI_BIT - 1);

  durum_t              durum_q, durum_d;
  bol_kod_t            kod_q, gelen_kod;
  logic [SAYAC_W-1:0]  sayac_q;
  logic                ilk_q;
  logic                neg_bolum_q, neg_kalan_q;
  logic [VERI_BIT-1:0] bolen_q, bolum_q, kalan_q, sonuc_q;
  logic [VERI_BIT-1:0] sonraki_kalan, sonraki_bolum;

  logic                isaretli, a_neg, b_neg;
  logic                sifira_bolme, tasma, ozel, kabul, son_adim;
  logic [VERI_BIT-1:0] a_buyukluk, b_buyukluk;
  logic                hazir_c, gecerli_c;
  logic [VERI_BIT-1:0] sonuc_c;

  // Decode the presented request: signedness, magnitudes, special cases.
  always_comb begin
    gelen_kod    = bol_kod_t'(bif.istek_kod_i);
    isaretli     = isaretli_mi(gelen_kod);
    a_neg        = isaretli & bif.bolunen_i[VERI_BIT-1];
    b_neg        = isaretli & bif.bolen_i[VERI_BIT-1];
    a_buyukluk   = a_neg ? -bif.bolunen_i : bif.bolunen_i;
    b_buyukluk   = b_neg ? -bif.bolen_i : bif.bolen_i;
    sifira_bolme = (bif.bolen_i == '0);
    tasma        = isaretli & (bif.bolunen_i == EN_KUCUK) & (bif.bolen_i == '1);
    ozel         = sifira_bolme | tasma;
    kabul        = bif.istek_gecerli_i & hazir_c & ~bif.bosalt_i;
    son_adim     = ~ilk_q & (sayac_q == SON_SAYI);
  end

  bolme_adimi #(.VERI_BIT(VERI_BIT)) u_adim (
    .kalan         (kalan_q),
    .bolum         (bolum_q),
    .bolen         (bolen_q),
    .sonraki_kalan (sonraki_kalan),
    .sonraki_bolum (sonraki_bolum)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) durum_q <= BOSTA;
    else         durum_q <= durum_d;
  end

  // Next state and handshake outputs; flush overrides every transition.
  always_comb begin
    durum_d   = durum_q;
    hazir_c   = 1'b0;
    gecerli_c = 1'b0;
    sonuc_c   = '0;
    case (durum_q)
      BOSTA: begin
        hazir_c = 1'b1;
        if (bif.istek_gecerli_i) durum_d = ozel ? OZEL : HESAPLA;
      end
      HESAPLA: if (son_adim) durum_d = DUZELT;
      DUZELT:  durum_d = BITTI;
      OZEL:    durum_d = BITTI;
      BITTI: begin
        gecerli_c = 1'b1;
        sonuc_c   = sonuc_q;
        durum_d   = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
    if (bif.bosalt_i) durum_d = BOSTA;
  end

  assign bif.istek_hazir_o   = hazir_c;
  assign bif.sonuc_gecerli_o = gecerli_c;
  assign bif.sonuc_o         = sonuc_c;
  assign bif.duraklat_o      = bif.istek_gecerli_i & ~gecerli_c;

  // Operand latch, iteration datapath, sign correction and result register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      kod_q       <= BOL_DIV;
      sayac_q     <= '0;
      ilk_q       <= 1'b0;
      neg_bolum_q <= 1'b0;
      neg_kalan_q <= 1'b0;
      bolen_q     <= '0;
      bolum_q     <= '0;
      kalan_q     <= '0;
      sonuc_q     <= '0;
    end else if (kabul) begin
      kod_q   <= gelen_kod;
      sayac_q <= '0;
      ilk_q   <= ~ozel;
      if (sifira_bolme) begin
        bolum_q     <= '1;
        kalan_q     <= bif.bolunen_i;
        bolen_q     <= '0;
        neg_bolum_q <= 1'b0;
        neg_kalan_q <= 1'b0;
      end else if (tasma) begin
        bolum_q     <= EN_KUCUK;
        kalan_q     <= '0;
        bolen_q     <= '0;
        neg_bolum_q <= 1'b0;
        neg_kalan_q <= 1'b0;
      end else begin
        bolum_q     <= a_buyukluk;
        kalan_q     <= '0;
        bolen_q     <= b_buyukluk;
        neg_bolum_q <= a_neg ^ b_neg;
        neg_kalan_q <= a_neg;
      end
    end else begin
      case (durum_q)
        // First HESAPLA cycle is an alignment slot; the counter holds at 0.
        HESAPLA: begin
          if (ilk_q) begin
            ilk_q <= 1'b0;
          end else begin
            kalan_q <= sonraki_kalan;
            bolum_q <= sonraki_bolum;
            if (!son_adim) sayac_q <= sayac_q + SAYAC_W'(1);
          end
        end
        DUZELT: begin
          if (kalan_mi(kod_q)) sonuc_q <= neg_kalan_q ? -kalan_q : kalan_q;
          else                 sonuc_q <= neg_bolum_q ? -bolum_q : bolum_q;
        end
        OZEL: sonuc_q <= kalan_mi(kod_q) ? kalan_q : bolum_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bolme_denetleyici.sv
// Directed, table-driven bench for the divide controller.
module tb_bolme_denetleyici;

  localparam int unsigned W = 32;

  typedef struct {
    logic [1:0]   kod;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] beklenen;
    int           gecikme;
    string        ad;
  } vektor_t;

  logic clk;
  logic rstn;
  int   karsilastirma;
  int   hata;

  bolme_denetleyici_if #(.VERI_BIT(W)) bif ();

  bolme_denetleyici #(.VERI_BIT(W)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bif    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic kontrol(input string ad, input logic [W-1:0] gercek, input logic [W-1:0] beklenen);
    karsilastirma++;
    if (gercek !== beklenen) begin
      hata++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", ad, gercek, beklenen);
    end
  endtask

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  function automatic vektor_t vek(input logic [1:0] kod, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] beklenen, input int gecikme, input string ad);
    vektor_t v;
    v.kod = kod; v.a = a; v.b = b; v.beklenen = beklenen; v.gecikme = gecikme; v.ad = ad;
    return v;
  endfunction

  // Present one request, wait for its strobe, check latency, result and stall.
  task automatic islem(input vektor_t v);
    bit goruldu;
    bit ara_hata;
    int k;
    bif.istek_kod_i     = v.kod;
    bif.bolunen_i       = v.a;
    bif.bolen_i         = v.b;
    bif.istek_gecerli_i = 1'b1;
    goruldu  = 1'b0;
    ara_hata = 1'b0;
    k        = 0;
    for (int i = 0; i < 60 && !goruldu; i++) begin
      adim();
      k = i;
      if (bif.sonuc_gecerli_o) goruldu = 1'b1;
      else if (bif.duraklat_o !== 1'b1 || bif.sonuc_o !== '0 || bif.istek_hazir_o !== 1'b0) ara_hata = 1'b1;
    end
    kontrol({v.ad, " strobe"}, W'(goruldu), W'(1));
    if (goruldu) begin
      kontrol({v.ad, " latency"}, W'(k), W'(v.gecikme));
      kontrol({v.ad, " result"}, bif.sonuc_o, v.beklenen);
      kontrol({v.ad, " stall_drop"}, W'(bif.duraklat_o), W'(0));
    end
    kontrol({v.ad, " busy_window"}, W'(ara_hata), W'(0));
    bif.istek_gecerli_i = 1'b0;
    adim();
    kontrol({v.ad, " idle_ready"}, W'(bif.istek_hazir_o), W'(1));
    kontrol({v.ad, " idle_strobe"}, W'(bif.sonuc_gecerli_o), W'(0));
  endtask

  // Count strobes over a number of cycles with the request deasserted.
  task automatic sessiz(input string ad, input int dongu);
    int n;
    n = 0;
    for (int i = 0; i < dongu; i++) begin
      adim();
      if (bif.sonuc_gecerli_o) n++;
    end
    kontrol(ad, W'(n), W'(0));
  endtask

  vektor_t tablo[18];

  initial begin
    karsilastirma = 0;
    hata          = 0;
    rstn                = 1'b0;
    bif.bosalt_i        = 1'b0;
    bif.istek_gecerli_i = 1'b0;
    bif.istek_kod_i     = 2'b00;
    bif.bolunen_i       = '0;
    bif.bolen_i         = '0;

    tablo[0]  = vek(2'b01, 32'd100,        32'd7,          32'd14,         34, "DIVU 100/7");
    tablo[1]  = vek(2'b00, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   34, "DIV -100/7");
    tablo[2]  = vek(2'b10, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   34, "REM -100/7");
    tablo[3]  = vek(2'b11, 32'd100,        32'd7,          32'd2,          34, "REMU 100/7");
    tablo[4]  = vek(2'b00, 32'd5,          32'd0,          32'hFFFFFFFF,   1,  "DIV 5/0");
    tablo[5]  = vek(2'b10, 32'd5,          32'd0,          32'd5,          1,  "REM 5/0");
    tablo[6]  = vek(2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1,  "DIV ovf");
    tablo[7]  = vek(2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1,  "REM ovf");
    tablo[8]  = vek(2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,          34, "DIVU big");
    tablo[9]  = vek(2'b11, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   34, "REMU big");
    tablo[10] = vek(2'b00, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   34, "DIV 100/-7");
    tablo[11] = vek(2'b10, 32'd100,        32'hFFFFFFF9,   32'd2,          34, "REM 100/-7");
    tablo[12] = vek(2'b00, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          34, "DIV -7/-2");
    tablo[13] = vek(2'b10, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'hFFFFFFFF,   34, "REM -7/-2");
    tablo[14] = vek(2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   34, "DIVU max/1");
    tablo[15] = vek(2'b11, 32'd7,          32'd100,        32'd7,          34, "REMU 7/100");
    tablo[16] = vek(2'b01, 32'd5,          32'd0,          32'hFFFFFFFF,   1,  "DIVU 5/0");
    tablo[17] = vek(2'b11, 32'd5,          32'd0,          32'd5,          1,  "REMU 5/0");

    // Reset state.
    repeat (2) adim();
    kontrol("reset ready",  W'(bif.istek_hazir_o),   W'(1));
    kontrol("reset strobe", W'(bif.sonuc_gecerli_o), W'(0));
    kontrol("reset result", bif.sonuc_o,             W'(0));
    kontrol("reset stall",  W'(bif.duraklat_o),      W'(0));
    rstn = 1'b1;
    adim();

    foreach (tablo[i]) islem(tablo[i]);

    // Flush at edge 10 of a DIVU; the flushed uop leaves execute with it.
    bif.istek_kod_i     = 2'b01;
    bif.bolunen_i       = 32'd100;
    bif.bolen_i         = 32'd7;
    bif.istek_gecerli_i = 1'b1;
    repeat (10) adim();
    kontrol("pre-flush ready", W'(bif.istek_hazir_o), W'(0));
    bif.bosalt_i        = 1'b1;
    bif.istek_gecerli_i = 1'b0;
    adim();
    kontrol("flush ready",  W'(bif.istek_hazir_o),   W'(1));
    kontrol("flush strobe", W'(bif.sonuc_gecerli_o), W'(0));
    bif.bosalt_i = 1'b0;
    sessiz("flush no strobe", 40);
    islem(vek(2'b01, 32'd100, 32'd7, 32'd14, 34, "DIVU after flush"));

    // Back-to-back: request held; yurut advances to the next uop on the strobe.
    begin
      int n;
      n = 0;
      bif.istek_kod_i     = 2'b01;
      bif.bolunen_i       = 32'd1000;
      bif.bolen_i         = 32'd10;
      bif.istek_gecerli_i = 1'b1;
      for (int i = 0; i < 150; i++) begin
        adim();
        if (bif.sonuc_gecerli_o) begin
          n++;
          if (n == 1) begin
            kontrol("b2b first result", bif.sonuc_o, 32'd100);
            bif.bolunen_i = 32'd81;
            bif.bolen_i   = 32'd9;
          end else if (n == 2) begin
            kontrol("b2b second result", bif.sonuc_o, 32'd9);
            bif.istek_gecerli_i = 1'b0;
          end
        end
      end
      kontrol("b2b strobe count", W'(n), W'(2));
    end

    // Reset in the middle of HESAPLA.
    bif.istek_kod_i     = 2'b01;
    bif.bolunen_i       = 32'd1000;
    bif.bolen_i         = 32'd3;
    bif.istek_gecerli_i = 1'b1;
    repeat (12) adim();
    rstn                = 1'b0;
    bif.istek_gecerli_i = 1'b0;
    adim();
    kontrol("midreset ready",  W'(bif.istek_hazir_o),   W'(1));
    kontrol("midreset strobe", W'(bif.sonuc_gecerli_o), W'(0));
    kontrol("midreset result", bif.sonuc_o,             W'(0));
    rstn = 1'b1;
    sessiz("midreset no strobe", 40);
    islem(vek(2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "DIV -7/2 after reset"));
    islem(vek(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "REM -7/2 after reset"));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", karsilastirma, hata);
    $finish;
  end

endmodule
